// File: rtl/alu_pkg.sv
// Shared types and constants for the 6502 add/subtract pipeline.
// The low-nibble decimal fixup lives here so stage 1 stays readable.
package alu_pkg;

  localparam logic ALU_ADC = 1'b0;
  localparam logic ALU_SBC = 1'b1;

  localparam logic [3:0] BCD_ADJ_LO = 4'h6;
  localparam logic [7:0] BCD_ADJ_HI = 8'h60;
  localparam logic [4:0] BCD_LIM_LO = 5'h0A;
  localparam logic [8:0] BCD_LIM_HI = 9'h0A0;

  typedef struct packed {
    logic [5:0] al;
    logic [3:0] a_hi;
    logic [3:0] b_hi;
    logic       op_sub;
    logic       dec;
    logic       c;
    logic       n;
    logic       v;
    logic       z;
    logic [7:0] sum8;
  } s1_payload_t;

  // ADC: al is unsigned 0..31. SBC: al is signed -16..15, and the corrected
  // value (x - 16) with x in 0..15 is exactly {2'b11, x} in 6-bit two's complement.
  function automatic logic [5:0] bcd_lo_adjust(input logic sub, input logic [5:0] raw);
    logic [3:0] up;
    logic [3:0] dn;
    up = raw[3:0] + BCD_ADJ_LO;
    dn = raw[3:0] - BCD_ADJ_LO;
    if (sub) begin
      return raw[5] ? {2'b11, dn} : raw;
    end
    return (raw[4:0] >= BCD_LIM_LO) ? {2'b01, up} : raw;
  endfunction

endpackage

// File: rtl/nibble_carry_add.sv
// 4-bit ripple adder from xor-carry (sum) and mux-carry (carry) cells.
module nibble_carry_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] carry;
  logic [3:0] prop;

  assign carry[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign prop[i]      = a[i] ^ b[i];
    assign sum[i]       = prop[i] ^ carry[i];
    // When the bits differ the carry propagates, otherwise both equal a[i].
    assign carry[i + 1] = prop[i] ? carry[i] : a[i];
  end

  assign c_out = carry[4];

endmodule

// File: rtl/alu_bcd_pipe.sv
// Two-stage 8-bit ADC/SBC pipeline with NMOS-accurate BCD correction.
// Stage 1: binary sum and decimal low nibble; stage 2: high-nibble fixup and flags.
module alu_bcd_pipe
  import alu_pkg::*;
#(
  parameter bit NMOS_FLAGS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       op_sub,
  input  logic       dec,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_v
);

  logic        s1_valid;
  logic        s2_can_load;
  s1_payload_t s1_d;
  s1_payload_t s1_q;

  assign s2_can_load = !out_valid || out_ready;
  assign in_ready    = !s1_valid || s2_can_load;

  // ---------------- stage 1 ----------------
  logic [7:0] bb;
  logic [3:0] sum_lo;
  logic [3:0] sum_hi;
  logic       c4;
  logic       c8;
  logic [7:0] sum8;
  logic [5:0] al_raw;

  assign bb = (op_sub == ALU_ADC) ? b : ~b;

  nibble_carry_add u_add_lo (
    .a     (a[3:0]),
    .b     (bb[3:0]),
    .c_in  (c_in),
    .sum   (sum_lo),
    .c_out (c4)
  );

  nibble_carry_add u_add_hi (
    .a     (a[7:4]),
    .b     (bb[7:4]),
    .c_in  (c4),
    .sum   (sum_hi),
    .c_out (c8)
  );

  assign sum8 = {sum_hi, sum_lo};

  // For SBC the low adder computes a_lo + ~b_lo + c = (a_lo - b_lo + c - 1) + 16.
  assign al_raw = {1'b0, c4, sum_lo} - ((op_sub == ALU_SBC) ? 6'd16 : 6'd0);

  always_comb begin
    s1_d        = '0;
    s1_d.al     = bcd_lo_adjust(op_sub, al_raw);
    s1_d.a_hi   = a[7:4];
    s1_d.b_hi   = b[7:4];
    s1_d.op_sub = op_sub;
    s1_d.dec    = dec;
    s1_d.c      = c8;
    s1_d.n      = sum8[7];
    s1_d.v      = ~(a[7] ^ bb[7]) & (a[7] ^ sum8[7]);
    s1_d.z      = (sum8 == 8'h00);
    s1_d.sum8   = sum8;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // ---------------- stage 2 ----------------
  logic [8:0]        t_add;
  logic [9:0]        t_add_adj;
  logic              c_dec;
  logic              v_dec;
  logic signed [9:0] t_sub;
  logic              t_neg;
  logic [7:0]        res_sub;

  assign t_add     = {1'b0, s1_q.a_hi, 4'h0} + {1'b0, s1_q.b_hi, 4'h0} + {3'b000, s1_q.al};
  assign t_add_adj = (t_add >= BCD_LIM_HI) ? ({1'b0, t_add} + {2'b00, BCD_ADJ_HI})
                                           : {1'b0, t_add};
  assign c_dec     = (t_add_adj >= 10'h100);
  assign v_dec     = ~(s1_q.a_hi[3] ^ s1_q.b_hi[3]) & (s1_q.a_hi[3] ^ t_add[7]);

  assign t_sub   = {2'b00, s1_q.a_hi, 4'h0} - {2'b00, s1_q.b_hi, 4'h0}
                 + {{4{s1_q.al[5]}}, s1_q.al};
  assign t_neg   = (t_sub < 10'sd0);
  assign res_sub = t_sub[7:0] - (t_neg ? BCD_ADJ_HI : 8'h00);

  logic [7:0] res_d;
  logic       c_d;
  logic       n_d;
  logic       v_d;
  logic       z_d;

  always_comb begin
    res_d = s1_q.sum8;
    c_d   = s1_q.c;
    n_d   = s1_q.n;
    v_d   = s1_q.v;
    z_d   = s1_q.z;
    if (s1_q.dec) begin
      if (s1_q.op_sub == ALU_SBC) begin
        res_d = res_sub;
      end else begin
        res_d = t_add_adj[7:0];
        c_d   = c_dec;
        v_d   = v_dec;
        n_d   = t_add[7];
      end
      // 65C02 rules: N and Z reflect the corrected decimal result.
      if (!NMOS_FLAGS) begin
        n_d = res_d[7];
        z_d = (res_d == 8'h00);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= 8'h00;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
    end else if (s2_can_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= res_d;
        flag_c <= c_d;
        flag_z <= z_d;
        flag_n <= n_d;
        flag_v <= v_d;
      end
    end
  end

endmodule

// File: tb/tb_alu_bcd_pipe.sv
// Bench for alu_bcd_pipe: NMOS and 65C02 flag variants run in lockstep,
// hand-derived vectors plus random traffic checked through an expected-result queue.
module tb_alu_bcd_pipe;

  typedef struct packed {
    logic [7:0] result;
    logic       c;
    logic       n;
    logic       v;
    logic       z;
    logic       n0;
    logic       z0;
  } exp_t;

  typedef struct packed {
    logic       op_sub;
    logic       dec;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    exp_t       e;
  } vec_t;

  logic clk;
  logic reset;
  logic in_valid;
  logic op_sub;
  logic dec;
  logic [7:0] a;
  logic [7:0] b;
  logic c_in;
  logic out_ready;

  logic in_ready_n, out_valid_n, fc_n, fz_n, fn_n, fv_n;
  logic in_ready_c, out_valid_c, fc_c, fz_c, fn_c, fv_c;
  logic [7:0] r_n, r_c;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_out   = 0;
  int n_disc  = 0;
  int cyc     = 0;
  exp_t exp_q[$];
  vec_t tbl[12];

  alu_bcd_pipe #(.NMOS_FLAGS(1'b1)) dut_n (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_n),
    .op_sub(op_sub), .dec(dec), .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid_n), .out_ready(out_ready), .result(r_n),
    .flag_c(fc_n), .flag_z(fz_n), .flag_n(fn_n), .flag_v(fv_n)
  );

  alu_bcd_pipe #(.NMOS_FLAGS(1'b0)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c),
    .op_sub(op_sub), .dec(dec), .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid_c), .out_ready(out_ready), .result(r_c),
    .flag_c(fc_c), .flag_z(fz_c), .flag_n(fn_c), .flag_v(fv_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic d, input logic [7:0] av,
                              input logic [7:0] bv, input logic cv, input logic [7:0] r,
                              input logic fc, input logic fn, input logic fv, input logic fz,
                              input logic n0, input logic z0);
    vec_t v;
    v.op_sub = s; v.dec = d; v.a = av; v.b = bv; v.c_in = cv;
    v.e.result = r; v.e.c = fc; v.e.n = fn; v.e.v = fv; v.e.z = fz;
    v.e.n0 = n0; v.e.z0 = z0;
    return v;
  endfunction

  // Reference arithmetic written directly from the 6502 decimal-mode formulas.
  function automatic exp_t model(input logic s, input logic d, input logic [7:0] av,
                                 input logic [7:0] bv, input logic cv);
    exp_t e;
    int ai, bi, bbi, sum, al, t, r;
    logic bc, bn, bv_f, bz;
    ai  = int'(av);
    bi  = int'(bv);
    bbi = s ? (bi ^ 255) : bi;
    sum = ai + bbi + int'(cv);
    bc  = (sum >= 256);
    bn  = ((sum & 128) != 0);
    bz  = ((sum & 255) == 0);
    bv_f = (((~(ai ^ bbi)) & (ai ^ sum) & 128) != 0);
    e.c = bc; e.n = bn; e.v = bv_f; e.z = bz;
    r = sum & 255;
    if (d && !s) begin
      al = (ai & 15) + (bi & 15) + int'(cv);
      if (al >= 10) al = ((al + 6) & 15) + 16;
      t = (ai & 240) + (bi & 240) + al;
      e.n = ((t & 128) != 0);
      e.v = (((~(ai ^ bi)) & (ai ^ t) & 128) != 0);
      if (t >= 160) t = t + 96;
      e.c = (t >= 256);
      r = t & 255;
    end else if (d && s) begin
      al = (ai & 15) - (bi & 15) + int'(cv) - 1;
      if (al < 0) al = ((al - 6) & 15) - 16;
      t = (ai & 240) - (bi & 240) + al;
      if (t < 0) t = t - 96;
      r = t & 255;
    end
    e.result = r[7:0];
    e.n0 = d ? r[7] : e.n;
    e.z0 = d ? (r[7:0] == 8'h00) : e.z;
    return e;
  endfunction

  task automatic send(input vec_t v);
    int guard;
    guard = 0;
    op_sub = v.op_sub; dec = v.dec; a = v.a; b = v.b; c_in = v.c_in;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready_n) begin
        exp_q.push_back(v.e);
        n_acc++;
        break;
      end
      guard++;
      if (guard > 60) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", guard);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("drain_pending", 16'(exp_q.size()), 16'd0);
  endtask

  // Output monitor: compares popped expectations and checks hold stability.
  initial begin
    logic       hold_prev;
    logic [23:0] prev_obs;
    exp_t e;
    hold_prev = 1'b0;
    prev_obs  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check("hold_valid", 16'(out_valid_n), 16'd1);
          check("hold_out_nmos", 16'({r_n, fc_n, fn_n, fv_n, fz_n}), 16'(prev_obs[23:12]));
          check("hold_out_cmos", 16'({r_c, fc_c, fn_c, fv_c, fz_c}), 16'(prev_obs[11:0]));
        end
        if (out_valid_n && exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL stale_output: result %02h presented, required no valid output", r_n);
        end else if (out_valid_n && out_ready) begin
          e = exp_q.pop_front();
          n_out++;
          check("cmos_valid", 16'(out_valid_c), 16'd1);
          check("nmos_out", 16'({r_n, fc_n, fn_n, fv_n, fz_n}),
                16'({e.result, e.c, e.n, e.v, e.z}));
          check("cmos_out", 16'({r_c, fc_c, fn_c, fv_c, fz_c}),
                16'({e.result, e.c, e.n0, e.v, e.z0}));
        end
        hold_prev = out_valid_n && !out_ready;
        prev_obs  = {r_n, fc_n, fn_n, fv_n, fz_n, r_c, fc_c, fn_c, fv_c, fz_c};
      end
    end
  end

  initial begin
    int c0;
    bit rand_done;
    vec_t rv;
    logic [7:0] snap;

    //            sub dec a      b      c  result C  N  V  Z  N0 Z0
    tbl[0]  = mk(0, 0, 8'h7F, 8'h01, 0, 8'h80, 0, 1, 1, 0, 1, 0);
    tbl[1]  = mk(0, 1, 8'h99, 8'h01, 0, 8'h00, 1, 1, 0, 0, 0, 1);
    tbl[2]  = mk(0, 1, 8'h58, 8'h46, 1, 8'h05, 1, 1, 1, 0, 0, 0);
    tbl[3]  = mk(1, 1, 8'h00, 8'h01, 1, 8'h99, 0, 1, 0, 0, 1, 0);
    tbl[4]  = mk(1, 1, 8'h46, 8'h12, 1, 8'h34, 1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 8'h50, 8'hB0, 1, 8'hA0, 0, 1, 1, 0, 1, 0);
    tbl[6]  = mk(0, 0, 8'hFF, 8'h01, 0, 8'h00, 1, 0, 0, 1, 0, 1);
    tbl[7]  = mk(0, 1, 8'h0F, 8'h0F, 0, 8'h14, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 8'h50, 8'h50, 0, 8'h00, 1, 1, 1, 0, 0, 1);
    tbl[9]  = mk(1, 1, 8'h10, 8'h01, 1, 8'h09, 1, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 1, 8'h00, 8'h00, 0, 8'h99, 0, 1, 0, 0, 1, 0);
    tbl[11] = mk(1, 1, 8'h00, 8'h00, 1, 8'h00, 1, 0, 0, 1, 0, 1);

    reset = 1'b1; in_valid = 1'b0; op_sub = 1'b0; dec = 1'b0;
    a = 8'h00; b = 8'h00; c_in = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 16'(out_valid_n), 16'd0);
    check("reset_result", 16'(r_n), 16'd0);
    check("reset_flags", 16'({fc_n, fz_n, fn_n, fv_n}), 16'd0);
    check("reset_in_ready", 16'({in_ready_n, in_ready_c}), 16'b11);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Latency: out_valid rises one edge after the accepting edge's follower.
    send(tbl[0]);
    check("latency_s1", 16'(out_valid_n), 16'd0);
    @(posedge clk);
    #1;
    check("latency_s2", 16'(out_valid_n), 16'd1);

    c0 = cyc;
    for (int i = 1; i < 12; i++) send(tbl[i]);
    check("throughput_cycles", 16'(cyc - c0), 16'd11);
    drain();

    // Random traffic with random back-pressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          rv.op_sub = 1'($urandom_range(0, 1));
          rv.dec    = 1'($urandom_range(0, 1));
          rv.a      = 8'($urandom_range(0, 255));
          rv.b      = 8'($urandom_range(0, 255));
          rv.c_in   = 1'($urandom_range(0, 1));
          rv.e      = model(rv.op_sub, rv.dec, rv.a, rv.b, rv.c_in);
          send(rv);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Back-pressure: 4 ops against a stalled consumer.
    out_ready = 1'b0;
    c0 = n_acc;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(tbl[i]);
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_accepts", 16'(n_acc - c0), 16'd2);
        check("bp_in_ready", 16'(in_ready_n), 16'd0);
        check("bp_out_valid", 16'(out_valid_n), 16'd1);
        snap = r_n;
        repeat (2) begin
          @(negedge clk);
          check("bp_result_stable", 16'(r_n), 16'(snap));
          check("bp_accepts_held", 16'(n_acc - c0), 16'd2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_no_loss", 16'(n_out), 16'(n_acc));

    // Reset with both stages occupied.
    out_ready = 1'b0;
    send(tbl[5]);
    send(tbl[6]);
    check("pre_reset_valid", 16'(out_valid_n), 16'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_out_valid", 16'(out_valid_n), 16'd0);
    check("rst_mid_result", 16'({r_n, r_c}), 16'd0);
    check("rst_mid_flags", 16'({fc_n, fz_n, fn_n, fv_n, fc_c, fz_c, fn_c, fv_c}), 16'd0);
    check("rst_mid_in_ready", 16'(in_ready_n), 16'd1);
    n_disc = n_disc + exp_q.size();
    exp_q.delete();
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(tbl[7]);
    drain();
    check("total_accounting", 16'(n_out + n_disc), 16'(n_acc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
